// File: rtl/pw_frame_encoder.sv
// Pulse-width serial frame encoder: buffers up to 2**ADDR_W words through a
// ready/valid load port, then sends sync, one pulse per bit (long high = 1,
// short high = 0) and a stop pattern on a single registered output wire.
module pw_frame_encoder #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 8,
    parameter int SYNC_HI   = 16,
    parameter int SYNC_LO   = 8,
    parameter int BIT0_HI   = 4,
    parameter int BIT1_HI   = 12,
    parameter int BIT_LO    = 4,
    parameter int STOP_LO   = 8,
    parameter int STOP_HI   = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Le,
    input  logic [ADDR_W-1:0] N,
    input  logic [DATA_W-1:0] Din,
    input  logic              Din_vld,
    output logic              Ld_rdy,
    input  logic              Abort,
    output logic              Dout,
    output logic              Busy,
    output logic              Done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_FIRST = (MSB_FIRST != 0) ? BIT_W'(DATA_W - 1) : '0;
    localparam logic [BIT_W-1:0] BIT_LAST  = (MSB_FIRST != 0) ? '0 : BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SYNC, S_DATA, S_STOP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] n_reg, n_d;
    logic [ADDR_W-1:0] idx, idx_d;       // load write index, then send word index
    logic [BIT_W-1:0]  bit_idx, bit_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CNT_W-1:0]  dur;
    logic              dout_d, done_d, wr_en;
    logic              cur_bit, phase_end;
    logic [DATA_W-1:0] mem [DEPTH];

    // Dout doubles as the high/low sub-phase flag of SYNC, DATA and STOP.
    assign Ld_rdy    = (state == S_LOAD);
    assign Busy      = (state != S_IDLE);
    assign cur_bit   = mem[idx][bit_idx];
    assign phase_end = (cnt == dur - CNT_W'(1));

    // Length of the phase currently being driven.
    always_comb begin
        dur = '0;
        case (state)
            S_SYNC:  dur = Dout ? CNT_W'(SYNC_HI) : CNT_W'(SYNC_LO);
            S_DATA:  dur = Dout ? (cur_bit ? CNT_W'(BIT1_HI) : CNT_W'(BIT0_HI)) : CNT_W'(BIT_LO);
            S_STOP:  dur = Dout ? CNT_W'(STOP_HI) : CNT_W'(STOP_LO);
            default: dur = '0;
        endcase
    end

    // Next-state, counter and output decode for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d = state;
        n_d     = n_reg;
        idx_d   = idx;
        bit_d   = bit_idx;
        cnt_d   = cnt;
        dout_d  = Dout;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        case (state)
            S_IDLE: begin
                dout_d = 1'b0;
                if (Le) begin
                    n_d     = N;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (Din_vld) begin
                    wr_en = 1'b1;
                    if (idx == n_reg) begin
                        state_d = S_SYNC;
                        idx_d   = '0;
                        bit_d   = BIT_FIRST;
                        cnt_d   = '0;
                        dout_d  = 1'b1;
                    end else begin
                        idx_d = idx + ADDR_W'(1);
                    end
                end
            end
            S_SYNC: begin
                cnt_d = phase_end ? '0 : cnt + CNT_W'(1);
                if (phase_end) begin
                    dout_d = ~Dout;
                    if (!Dout) state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = phase_end ? '0 : cnt + CNT_W'(1);
                if (phase_end) begin
                    if (Dout) begin
                        dout_d = 1'b0;
                    end else if (bit_idx == BIT_LAST) begin
                        bit_d = BIT_FIRST;
                        if (idx == n_reg) begin
                            state_d = S_STOP;
                        end else begin
                            idx_d  = idx + ADDR_W'(1);
                            dout_d = 1'b1;
                        end
                    end else begin
                        bit_d  = (MSB_FIRST != 0) ? bit_idx - BIT_W'(1) : bit_idx + BIT_W'(1);
                        dout_d = 1'b1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = phase_end ? '0 : cnt + CNT_W'(1);
                if (phase_end) begin
                    dout_d = ~Dout;
                    if (Dout) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops whatever frame is in progress; it means nothing in IDLE.
        if (Abort && state != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            dout_d  = 1'b0;
            done_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Rst) begin
            state   <= S_IDLE;
            n_reg   <= '0;
            idx     <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            Dout    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_d;
            n_reg   <= n_d;
            idx     <= idx_d;
            bit_idx <= bit_d;
            cnt     <= cnt_d;
            Dout    <= dout_d;
            Done    <= done_d;
        end
    end

    // Word buffer, written one accepted beat at a time.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: the buffer is reset on purpose so a frame never exposes stale data; this keeps it in flops.
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[idx] <= Din;
        end
    end

endmodule

// File: tb/tb_pw_frame_encoder.sv
// Self-checking bench: two encoders (LSB-first and MSB-first) share stimulus;
// a per-cycle expected trace of {Dout,Busy,Done,Ld_rdy} is queued for each.
module tb_pw_frame_encoder;

    localparam int SYNC_HI = 16, SYNC_LO = 8, BIT0_HI = 4, BIT1_HI = 12;
    localparam int BIT_LO = 4, STOP_LO = 8, STOP_HI = 4;

    typedef struct packed {
        logic dout;
        logic busy;
        logic done;
        logic ld_rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       le, din_vld, abort;
    logic [3:0] n_in;
    logic [7:0] din;
    logic       ld_l, dout_l, busy_l, done_l;
    logic       ld_m, dout_m, busy_m, done_m;

    int   checks   = 0;
    int   failures = 0;
    obs_t q_l[$];
    obs_t q_m[$];
    obs_t fq[$];
    logic [7:0] words [16];

    always #5 clk = ~clk;

    pw_frame_encoder dut_l (
        .Clk(clk), .Rst(rst_n), .Le(le), .N(n_in), .Din(din), .Din_vld(din_vld),
        .Ld_rdy(ld_l), .Abort(abort), .Dout(dout_l), .Busy(busy_l), .Done(done_l)
    );

    pw_frame_encoder #(.MSB_FIRST(1)) dut_m (
        .Clk(clk), .Rst(rst_n), .Le(le), .N(n_in), .Din(din), .Din_vld(din_vld),
        .Ld_rdy(ld_m), .Abort(abort), .Dout(dout_m), .Busy(busy_m), .Done(done_m)
    );

    task automatic cmp(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed={dout,busy,done,ld_rdy}=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk_both(input string tag, input obs_t e);
        cmp({tag, "_lsb"}, {dout_l, busy_l, done_l, ld_l}, e);
        cmp({tag, "_msb"}, {dout_m, busy_m, done_m, ld_m}, e);
    endtask

    // Scoreboard: one expected entry consumed per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q_l.size() > 0) cmp("lsb_trace", {dout_l, busy_l, done_l, ld_l}, q_l.pop_front());
        if (q_m.size() > 0) cmp("msb_trace", {dout_m, busy_m, done_m, ld_m}, q_m.pop_front());
    end

    task automatic seg(input logic lvl, input int len);
        for (int i = 0; i < len; i++) fq.push_back({lvl, 1'b1, 1'b0, 1'b0});
    endtask

    // Reference frame trace from the first SYNC cycle through the Done cycle.
    task automatic build_frame(input bit msb, input int n);
        int bi;
        fq.delete();
        seg(1'b1, SYNC_HI);
        seg(1'b0, SYNC_LO);
        for (int w = 0; w <= n; w++) begin
            for (int b = 0; b < 8; b++) begin
                bi = msb ? 7 - b : b;
                seg(1'b1, words[w][bi] ? BIT1_HI : BIT0_HI);
                seg(1'b0, BIT_LO);
            end
        end
        seg(1'b0, STOP_LO);
        seg(1'b1, STOP_HI);
        fq.push_back(4'b0010);
    endtask

    // keep < 0 queues the whole frame; otherwise only its first keep cycles.
    task automatic push_expected(input int n, input int keep, input int idle_after);
        for (int m = 0; m < 2; m++) begin
            build_frame(m[0], n);
            for (int i = 0; i < fq.size() && (keep < 0 || i < keep); i++) begin
                if (m == 0) q_l.push_back(fq[i]); else q_m.push_back(fq[i]);
            end
            for (int i = 0; i < idle_after; i++) begin
                if (m == 0) q_l.push_back(4'b0000); else q_m.push_back(4'b0000);
            end
        end
    endtask

    task automatic push_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            q_l.push_back(4'b0000);
            q_m.push_back(4'b0000);
        end
    endtask

    // Start request plus back-to-back load beats; optional 5-cycle stall.
    task automatic run_load(input int n, input int stall_after, input logic abort_with_le);
        le    = 1'b1;
        n_in  = 4'(n);
        abort = abort_with_le;
        @(posedge clk); #1;
        le    = 1'b0;
        abort = 1'b0;
        for (int i = 0; i <= n; i++) begin
            din     = words[i];
            din_vld = 1'b1;
            @(negedge clk);
            chk_both("load_rdy", 4'b0101);
            @(posedge clk); #1;
            din_vld = 1'b0;
            if (i == stall_after) begin
                din = 8'hFF;
                repeat (5) begin
                    @(negedge clk);
                    chk_both("stall_rdy", 4'b0101);
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q_l.size() > 0 || q_m.size() > 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        assert (q_l.size() == 0 && q_m.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout observed_left=%0d/%0d expected_left=0", q_l.size(), q_m.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; le = 1'b0; din_vld = 1'b0; abort = 1'b0; n_in = '0; din = '0;
        for (int i = 0; i < 16; i++) words[i] = '0;

        // Reset state.
        repeat (2) begin
            @(negedge clk);
            chk_both("reset_state", 4'b0000);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single word 0xA5, 132-cycle frame, Done then idle.
        words[0] = 8'hA5;
        run_load(0, -1, 1'b0);
        push_expected(0, -1, 3);
        drain(2000);

        // 2: sixteen words, 64 short pulses then 64 long pulses.
        for (int i = 0; i < 16; i++) words[i] = (i < 8) ? 8'h00 : 8'hFF;
        run_load(15, -1, 1'b0);
        push_expected(15, -1, 3);
        drain(2000);

        // 3: four words with a 5-cycle valid gap after word 1.
        words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h5A; words[3] = 8'h96;
        run_load(3, 1, 1'b0);
        push_expected(3, -1, 3);
        drain(2000);

        // 4: abort in the high part of bit 3 of word 0 (frame cycle 66).
        words[0] = 8'hA5;
        run_load(0, -1, 1'b0);
        push_expected(0, 67, 3);
        repeat (66) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        drain(200);
        // Le and Abort together in IDLE: Le wins, then a clean 0x01 frame.
        words[0] = 8'h01;
        run_load(0, -1, 1'b1);
        push_expected(0, -1, 3);
        drain(2000);

        // 5: asynchronous reset in the middle of DATA.
        words[0] = 8'hA5;
        run_load(0, -1, 1'b0);
        push_expected(0, -1, 0);
        repeat (40) begin
            @(posedge clk); #1;
        end
        #2;
        q_l.delete();
        q_m.delete();
        rst_n = 1'b0;
        #1;
        chk_both("async_reset", 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_idle(10);
        drain(100);

        // 6: 0x80 single word, checked in both bit orders.
        words[0] = 8'h80;
        run_load(0, -1, 1'b0);
        push_expected(0, -1, 3);
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pw_frame_encoder.md
Name: pw_frame_encoder

Overview:
Parametrised pulse-width serial frame encoder, the successor to the 8-bit/16-word pulse encoder.
- Buffers up to DEPTH words of DATA_W bits.
- Emits a frame on one wire: sync, then per-bit pulses, then stop. A "1" bit is a long high pulse; a "0" bit is a short high pulse.
- Adds over the previous block: a load handshake with stall, an abort input, Busy/Done status, bit-order selection and parametrised timing.
- Sits between the host bus and the line driver.

Parameters:
DATA_W, 8, bits per word
ADDR_W, 4, word-index width; DEPTH = 2**ADDR_W
CNT_W, 8, phase counter width; every duration below must be in 1..2**CNT_W-1
SYNC_HI, 16, sync high cycles
SYNC_LO, 8, sync low cycles
BIT0_HI, 4, high cycles for a 0 bit
BIT1_HI, 12, high cycles for a 1 bit
BIT_LO, 4, low cycles after every bit
STOP_LO, 8, stop low cycles
STOP_HI, 4, stop high cycles
MSB_FIRST, 0, 0 = bit 0 first, 1 = bit DATA_W-1 first

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  asynchronous active-low reset
Le  in  1  start request, sampled only in IDLE
N  in  ADDR_W  word count minus 1, latched when Le is accepted
Din  in  DATA_W  load data word
Din_vld  in  1  Din valid
Ld_rdy  out  1  high in LOAD; a word is accepted when Din_vld & Ld_rdy
Abort  in  1  synchronous abort
Dout  out  1  registered serial output
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse at normal frame completion

Behaviour:
- Reset (async, Rst=0):
  - State IDLE.
  - Dout=0, Busy=0, Done=0, Ld_rdy=0.
  - All counters, indices and the buffer are cleared.
  - Reset mid-frame drops the frame immediately with no Done.
- States: IDLE, LOAD, SYNC, DATA, STOP.
- IDLE:
  - Dout=0.
  - On Le=1: latch N into n_reg, set word index to 0, go to LOAD.
  - Le is ignored in every other state.
- LOAD:
  - Ld_rdy=1.
  - Each accepted beat writes buf[idx] and increments idx.
  - Din_vld=0 stalls indefinitely; no timeout.
  - The edge that accepts word n_reg enters SYNC, clears the phase counter and drives Dout<=1.
  - N=0 means a one-word frame.
- SYNC: Dout high for exactly SYNC_HI cycles, then low for exactly SYNC_LO cycles, then DATA.
- DATA:
  - Words are sent in order 0..n_reg. Bit order follows MSB_FIRST.
  - Each bit is Dout=1 for BIT1_HI (bit=1) or BIT0_HI (bit=0) cycles, then Dout=0 for BIT_LO cycles.
  - Bit cells are back-to-back, with no idle cycle between bits or words.
  - After the last bit of word n_reg, go to STOP.
  - The bit index wraps DATA_W-1 -> 0 (or 0 -> DATA_W-1) as the word index advances.
- STOP:
  - Dout=0 for STOP_LO cycles, then 1 for STOP_HI cycles.
  - On the next edge: Dout=0, Done=1 for one cycle, Busy=0, state IDLE.
- Frame length, measured from the first SYNC high cycle to the last STOP high cycle inclusive:
  SYNC_HI+SYNC_LO + Σbits(BITx_HI+BIT_LO) + STOP_LO+STOP_HI.
- Abort=1 in LOAD/SYNC/DATA/STOP:
  - Next edge forces IDLE with Dout=0 and Busy=0.
  - No Done.
  - Buffer contents are undefined afterwards.
  - Abort in IDLE has no effect. If Abort and Le are both high in IDLE, Le wins.
- Phase counter:
  - Counts 0..duration-1 within each phase and resets to 0 on every phase change.
  - Never wraps within a phase, given the parameter limits above.
- The buffer is rewritten on every frame. A new Le is accepted on the Done cycle's following edge at the earliest, i.e. the cycle after Done.

Test Plan:
1. Defaults, N=0, Din=8'hA5 (LSB first) -> bits 1,0,1,0,0,1,0,1; Dout high exactly 16 cycles after the load edge; frame = 132 cycles; Done one cycle later; Busy low afterwards.
2. N=15, words 0–7 = 8'h00, words 8–15 = 8'hFF -> frame = 24+512+1024+12 = 1572 cycles; 64 short then 64 long pulses; Done asserted once.
3. N=3, Din_vld deasserted for 5 cycles after word 1 -> Ld_rdy stays high; exactly 4 words stored; SYNC starts on the edge after word 3 is accepted; payload matches.
4. Abort during bit 3 of word 0 -> next cycle Dout=0, Busy=0, no Done; a following Le with N=0, Din=8'h01 produces a correct 132-cycle-class frame (recomputed length).
5. Rst pulled low mid-DATA -> Dout=0 and Busy=0 asynchronously; after release the block stays in IDLE until Le.
6. MSB_FIRST=1, N=0, Din=8'h80 -> first bit cell is 12 high / 4 low, followed by 7 cells of 4 high / 4 low.
